// File: rtl/mem_pkg.sv
// Shared types and constants for the memory stage.
// Holds the FSM state enum, funct3 size codes and the load result-select code.
package mem_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } mem_state_t;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

  // Halfword needs addr[0]=0, word needs addr[1:0]=0.
  function automatic logic is_misaligned(
    input logic [2:0] f3,
    input logic [1:0] a
  );
    return ((f3[1:0] == 2'b01) && a[0]) ||
           ((f3[1:0] == 2'b10) && (a != 2'b00));
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment: picks byte/half from the memory word and extends it.
// Ports: rdata (memory word), addr (low address bits), funct3 -> data.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata[7:0];
    unique case (addr)
      2'd0: b = rdata[7:0];
      2'd1: b = rdata[15:8];
      2'd2: b = rdata[23:16];
      2'd3: b = rdata[31:24];
    endcase
    h = addr[1] ? rdata[31:16] : rdata[15:0];
    data = rdata;
    unique case (1'b1)
      funct3 == F3_LB:  data = {{24{b[7]}}, b};
      funct3 == F3_LH:  data = {{16{h[15]}}, h};
      funct3 == F3_LBU: data = {24'd0, b};
      funct3 == F3_LHU: data = {16'd0, h};
      default:          data = rdata;
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory stage: EX/MEM register, dmem valid/ready request FSM, load alignment.
// Ports: E-stage inputs, StallM, dmem_* bus, M-stage writeback outputs
// (MisalignM only when MEM_MISALIGN_TRAP_EN is defined).
module memory_access
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic [1:0]      ResultSrcE,
  input  logic [2:0]      Funct3E,
  input  logic [XLEN-1:0] ALUResultE,
  input  logic [XLEN-1:0] WriteDataE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RdE,
  output logic            StallM,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_addr,
  output logic            dmem_we,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic            MisalignM,
`endif
  output logic            RegWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] ReadDataM,
  output logic [4:0]      RdM,
  output logic [XLEN-1:0] PCPlus4M
);

  logic        reg_write_q,  reg_write_d;
  logic        mem_write_q,  mem_write_d;
  logic [1:0]  result_src_q, result_src_d;
  logic [2:0]  funct3_q,     funct3_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [31:0] write_data_q, write_data_d;
  logic [31:0] pc_plus4_q,   pc_plus4_d;
  logic [4:0]  rd_q,         rd_d;
  logic [31:0] read_data_q,  read_data_d;
  mem_state_t  state_q,      state_d;

  logic        is_load_m, mem_op_m, mem_op_e;
  logic        mis_m, mis_e, stall;
  logic [31:0] aligned;

  load_align u_align (
    .rdata  (dmem_rdata),
    .addr   (alu_result_q[1:0]),
    .funct3 (funct3_q),
    .data   (aligned)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  assign mis_m = is_misaligned(funct3_q, alu_result_q[1:0]);
  assign mis_e = is_misaligned(Funct3E, ALUResultE[1:0]);
`else
  assign mis_m = 1'b0;
  assign mis_e = 1'b0;
`endif

  assign is_load_m = result_src_q == RESULT_SRC_LOAD;
  assign mem_op_m  = mem_write_q | is_load_m;
  assign mem_op_e  = MemWriteE | (ResultSrcE == RESULT_SRC_LOAD);
  assign stall     = mem_op_m && (state_q != S_DONE);

  always_comb begin
    reg_write_d  = reg_write_q;
    mem_write_d  = mem_write_q;
    result_src_d = result_src_q;
    funct3_d     = funct3_q;
    alu_result_d = alu_result_q;
    write_data_d = write_data_q;
    pc_plus4_d   = pc_plus4_q;
    rd_d         = rd_q;
    read_data_d  = read_data_q;
    state_d      = state_q;
    if (!stall) begin
      reg_write_d  = RegWriteE;
      mem_write_d  = MemWriteE;
      result_src_d = ResultSrcE;
      funct3_d     = Funct3E;
      alu_result_d = ALUResultE;
      write_data_d = WriteDataE;
      pc_plus4_d   = PCPlus4E;
      rd_d         = RdE;
    end
    unique case (state_q)
      S_IDLE:
        if (mem_op_m) state_d = mis_m ? S_DONE : S_REQ;
      S_REQ:
        if (dmem_req_ready) state_d = S_WAIT;
      S_WAIT:
        if (dmem_rsp_valid) begin
          read_data_d = is_load_m ? aligned : 32'd0;
          state_d     = S_DONE;
        end
      // Back-to-back memory ops skip the IDLE cycle.
      S_DONE:
        state_d = (mem_op_e && !mis_e) ? S_REQ : S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 2'b00;
      funct3_q     <= 3'b000;
      alu_result_q <= 32'd0;
      write_data_q <= 32'd0;
      pc_plus4_q   <= 32'd0;
      rd_q         <= 5'd0;
      read_data_q  <= 32'd0;
      state_q      <= S_IDLE;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      funct3_q     <= funct3_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
      rd_q         <= rd_d;
      read_data_q  <= read_data_d;
      state_q      <= state_d;
    end
  end

  // Lanes/data are zero for non-stores so a bubble drives an idle bus.
  always_comb begin
    dmem_be    = 4'b0000;
    dmem_wdata = 32'd0;
    if (mem_write_q) begin
      unique case (funct3_q[1:0])
        2'b00: begin
          dmem_be    = 4'b0001 << alu_result_q[1:0];
          dmem_wdata = {4{write_data_q[7:0]}};
        end
        2'b01: begin
          dmem_be    = alu_result_q[1] ? 4'b1100 : 4'b0011;
          dmem_wdata = {2{write_data_q[15:0]}};
        end
        default: begin
          dmem_be    = 4'b1111;
          dmem_wdata = write_data_q;
        end
      endcase
    end
  end

  assign StallM         = stall;
  assign dmem_req_valid = state_q == S_REQ;
  assign dmem_addr      = {alu_result_q[31:2], 2'b00};
  assign dmem_we        = mem_write_q;

`ifdef MEM_MISALIGN_TRAP_EN
  assign MisalignM = (state_q == S_DONE) && mis_m;
  assign RegWriteM = reg_write_q && !MisalignM;
`else
  assign RegWriteM = reg_write_q;
`endif

  assign ResultSrcM = result_src_q;
  assign ALUResultM = alu_result_q;
  assign ReadDataM  = read_data_q;
  assign RdM        = rd_q;
  assign PCPlus4M   = pc_plus4_q;

endmodule

// File: tb/tb_memory_access.sv
// Bench for memory_access: directed and random instructions against a model.
// Drives E inputs as the execute stage and plays a random-latency memory.
module tb_memory_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteE, MemWriteE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  Funct3E;
  logic [31:0] ALUResultE, WriteDataE, PCPlus4E;
  logic [4:0]  RdE;
  logic        StallM, dmem_req_valid, dmem_req_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        dmem_we, dmem_rsp_valid;
  logic [3:0]  dmem_be;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, ReadDataM, PCPlus4M;
  logic [4:0]  RdM;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        MisalignM;
`endif

  always #5 clk = ~clk;

  memory_access dut (
    .clk            (clk),
    .rst            (rst),
    .RegWriteE      (RegWriteE),
    .MemWriteE      (MemWriteE),
    .ResultSrcE     (ResultSrcE),
    .Funct3E        (Funct3E),
    .ALUResultE     (ALUResultE),
    .WriteDataE     (WriteDataE),
    .PCPlus4E       (PCPlus4E),
    .RdE            (RdE),
    .StallM         (StallM),
    .dmem_req_valid (dmem_req_valid),
    .dmem_req_ready (dmem_req_ready),
    .dmem_addr      (dmem_addr),
    .dmem_we        (dmem_we),
    .dmem_be        (dmem_be),
    .dmem_wdata     (dmem_wdata),
    .dmem_rsp_valid (dmem_rsp_valid),
    .dmem_rdata     (dmem_rdata),
`ifdef MEM_MISALIGN_TRAP_EN
    .MisalignM      (MisalignM),
`endif
    .RegWriteM      (RegWriteM),
    .ResultSrcM     (ResultSrcM),
    .ALUResultM     (ALUResultM),
    .ReadDataM      (ReadDataM),
    .RdM            (RdM),
    .PCPlus4M       (PCPlus4M)
  );

  typedef struct {
    logic        rw;
    logic        mw;
    logic [1:0]  rs;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [4:0]  rd;
  } ins_t;

  int checks = 0;
  int errors = 0;
  bit prev_mem = 0;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_load(ins_t i);
    return i.rs == 2'b01;
  endfunction

  function automatic bit is_mem(ins_t i);
    return i.mw || is_load(i);
  endfunction

  function automatic bit misal(ins_t i);
`ifdef MEM_MISALIGN_TRAP_EN
    int a;
    a = int'(i.alu % 4);
    if (i.f3 == 3'b001 || i.f3 == 3'b101) return (a % 2) != 0;
    if (i.f3 == 3'b010) return a != 0;
    return 0;
`else
    return 0;
`endif
  endfunction

  function automatic logic [31:0] exp_load(ins_t i, logic [31:0] rd);
    int a;
    logic [31:0] v;
    a = int'(i.alu % 4);
    case (i.f3)
      3'b000, 3'b100: begin
        v = (rd >> (8 * a)) % 256;
        if (i.f3 == 3'b000 && v >= 128) v = v - 256;
      end
      3'b001, 3'b101: begin
        v = (rd >> (16 * (a / 2))) % 65536;
        if (i.f3 == 3'b001 && v >= 32768) v = v - 65536;
      end
      default: v = rd;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] exp_be(ins_t i);
    int a;
    a = int'(i.alu % 4);
    if (i.f3[1:0] == 2'b00) return 4'(1 << a);
    if (i.f3[1:0] == 2'b01) return 4'(3 << (2 * (a / 2)));
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(ins_t i);
    if (i.f3[1:0] == 2'b00) return (i.wd % 256) * 32'h01010101;
    if (i.f3[1:0] == 2'b01) return (i.wd % 65536) * 32'h00010001;
    return i.wd;
  endfunction

  task automatic drive_e(ins_t i);
    RegWriteE  = i.rw;
    MemWriteE  = i.mw;
    ResultSrcE = i.rs;
    Funct3E    = i.f3;
    ALUResultE = i.alu;
    WriteDataE = i.wd;
    PCPlus4E   = i.pc;
    RdE        = i.rd;
  endtask

  // Runs one instruction through M; called at a negedge with StallM low.
  task automatic exec(ins_t i, int rdly, int sdly, logic [31:0] rdata);
    int cyc, rq, rs, exp_cyc;
    bit hs, mis, rdy;
    mis = is_mem(i) && misal(i);
    drive_e(i);
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'($urandom_range(0, 1));
    dmem_rdata     = $urandom;
    @(negedge clk);
    cyc = 1; rq = 0; rs = 0; hs = 0;
    while (StallM && cyc < 80) begin
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'($urandom_range(0, 1));
      dmem_rdata     = $urandom;
      if (dmem_req_valid) begin
        if (mis) check("misal_req", 1, 0);
        check("addr", dmem_addr, i.alu - (i.alu % 4));
        check("we", dmem_we, i.mw);
        if (i.mw) begin
          check("be", dmem_be, exp_be(i));
          check("wdata", dmem_wdata, exp_wdata(i));
        end
        rdy = (rq == rdly);
        dmem_req_ready = rdy;
        rq++;
        if (rdy) hs = 1;
      end else if (hs) begin
        dmem_rsp_valid = (rs == sdly);
        if (rs == sdly) dmem_rdata = rdata;
        rs++;
      end
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 80) check("timeout", 1, 0);
    if (!is_mem(i)) exp_cyc = 1;
    else if (mis) exp_cyc = 2;
    else exp_cyc = (prev_mem ? 0 : 1) + rdly + 1 + sdly + 1 + 1;
    check("cycles", cyc, exp_cyc);
    check("req_valid_done", dmem_req_valid, 0);
    check("rd", RdM, i.rd);
    check("alu", ALUResultM, i.alu);
    check("pc4", PCPlus4M, i.pc);
    check("rsrc", ResultSrcM, i.rs);
    check("regwrite", RegWriteM, i.rw && !mis);
`ifdef MEM_MISALIGN_TRAP_EN
    check("misalign", MisalignM, mis);
`endif
    if (is_mem(i) && !mis) begin
      if (is_load(i)) check("rdata", ReadDataM, exp_load(i, rdata));
      else check("rdata_st", ReadDataM, 0);
    end
    prev_mem = is_mem(i);
  endtask

  function automatic ins_t rand_ins();
    ins_t i;
    logic [2:0] lf3 [5];
    int k;
    lf3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    k = $urandom_range(0, 2);
    i.rw  = 1'($urandom_range(0, 1));
    i.alu = $urandom;
    i.wd  = $urandom;
    i.pc  = $urandom;
    i.rd  = 5'($urandom);
    i.mw  = (k == 2);
    i.rs  = (k == 1) ? 2'b01 : ($urandom_range(0, 1) ? 2'b10 : 2'b00);
    i.f3  = (k == 1) ? lf3[$urandom_range(0, 4)] : 3'($urandom_range(0, 2));
    return i;
  endfunction

  ins_t bubble = '{0, 0, 2'b00, 3'b000, 32'd0, 32'd0, 32'd0, 5'd0};

  task automatic check_zero(string tag);
    check({tag, "_stall"}, StallM, 0);
    check({tag, "_valid"}, dmem_req_valid, 0);
    check({tag, "_addr"}, dmem_addr, 0);
    check({tag, "_we"}, dmem_we, 0);
    check({tag, "_be"}, dmem_be, 0);
    check({tag, "_wdata"}, dmem_wdata, 0);
    check({tag, "_regw"}, RegWriteM, 0);
    check({tag, "_rsrc"}, ResultSrcM, 0);
    check({tag, "_alu"}, ALUResultM, 0);
    check({tag, "_rdata"}, ReadDataM, 0);
    check({tag, "_rd"}, RdM, 0);
    check({tag, "_pc4"}, PCPlus4M, 0);
`ifdef MEM_MISALIGN_TRAP_EN
    check({tag, "_mis"}, MisalignM, 0);
`endif
  endtask

  initial begin
    ins_t t;
    int n;
    rst = 1'b1;
    drive_e(bubble);
    dmem_req_ready = 0;
    dmem_rsp_valid = 0;
    dmem_rdata     = 0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    t = '{1, 0, 2'b00, 3'b000, 32'h1234, 32'd0, 32'h44, 5'd5};
    exec(t, 0, 0, 0);
    t = '{1, 0, 2'b01, 3'b000, 32'h103, 32'd0, 32'h48, 5'd6};
    exec(t, 0, 0, 32'h80FFFFFF);
    t = '{1, 0, 2'b01, 3'b101, 32'h102, 32'd0, 32'h4C, 5'd7};
    exec(t, 2, 2, 32'hBEEF1234);
    t = '{0, 1, 2'b00, 3'b000, 32'h201, 32'hAB, 32'h50, 5'd0};
    exec(t, 0, 0, 0);
    t = '{1, 0, 2'b01, 3'b010, 32'h102, 32'd0, 32'h54, 5'd8};
    exec(t, 1, 0, 32'hCAFEF00D);

    for (int k = 0; k < 200; k++)
      exec(rand_ins(), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);

    // Reset while waiting for a response; the late response must be dropped.
    t = '{1, 0, 2'b01, 3'b010, 32'h300, 32'd0, 32'h60, 5'd9};
    drive_e(t);
    dmem_req_ready = 1'b1;
    dmem_rsp_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!dmem_req_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rst_req_seen", dmem_req_valid, 1);
    dmem_req_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    drive_e(bubble);
    @(negedge clk);
    check_zero("rst_wait");
    rst = 1'b0;
    dmem_rsp_valid = 1'b1;
    dmem_rdata     = 32'hDEADBEEF;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    check_zero("late_rsp");
    prev_mem = 0;

    for (int k = 0; k < 30; k++)
      exec(rand_ins(), $urandom_range(0, 2), $urandom_range(0, 2), $urandom);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
